tx_iq_dac_pace: RTL and testbench
=================================

# tx_iq_dac_pace

Sample-pacing and 2x interpolation stage between `tx_iq_intf` and the DAC/RF front end. It generates the periodic `wifi_iq_ready` read strobe for `tx_iq_intf`, and captures the lower `{q,i}` word of `wifi_iq_pack` on each strobe. Each input period it emits two DAC samples: the previous sample, then the midpoint between the previous and the newest sample. It ramps in from and out to zero on enable/disable, and counts underruns (strobe with no valid data).

## Interface
Parameters:
- `WIFI_IQ_PACK_DATA_WIDTH`, 64: width of the input pack; only bits `[2*IQ_DATA_WIDTH-1:0]` are used.
- `IQ_DATA_WIDTH`, 16: signed I/Q sample width.
- `DIV_WIDTH`, 8: width of `rate_div`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request.
- `rate_div`  in  DIV_WIDTH  input-sample period minus 1, in clocks. Values below 3 are treated as 3.
- `wifi_iq_pack`  in  WIFI_IQ_PACK_DATA_WIDTH  `{…, q[31:16], i[15:0]}` from `tx_iq_intf`.
- `wifi_iq_valid`  in  1  pack holds valid data (FWFT semantics).
- `wifi_iq_ready`  out  1  one-cycle read strobe to `tx_iq_intf`.
- `dac_i`, `dac_q`  out  IQ_DATA_WIDTH each  signed output samples.
- `dac_valid`  out  1  one-cycle strobe marking a new `dac_i`/`dac_q`.
- `underrun_cnt`  out  16  sticky, saturating underrun count.
- `underrun_clr`  in  1  synchronous clear of `underrun_cnt`.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DRAIN}
  - `cnt` (DIV_WIDTH bits)
  - `div_l`: latched `max(rate_div,3)`
  - `half = (div_l+1)>>1`
  - `prev`, `cur`: 2×IQ each
  - `underrun_cnt`
- IDLE:
  - `cnt`=0, `prev`=`cur`=0, `wifi_iq_ready`=0, `dac_valid`=0.
  - On `enable`=1, at the next edge: go to RUN, latch `div_l`, `cnt`=0.
- RUN/DRAIN counter: `cnt` counts 0..`div_l` and wraps to 0.
- `wifi_iq_ready` = (state==RUN && cnt==0), decoded from registers only. It is high for exactly one cycle per period.
- Edge ending a cycle with cnt==0, in RUN or DRAIN:
  - Sample source: `wifi_iq_pack[31:0]` if RUN and `wifi_iq_valid`. Otherwise 0.
  - RUN with `wifi_iq_valid`=0 is an underrun: `underrun_cnt` += 1, saturating at 0xFFFF.
  - Register updates: `prev`←`cur`, `cur`←sample, `dac`←old `cur`, `dac_valid`←1.
- Edge ending a cycle with cnt==`half`:
  - `dac_i` ← (`prev_i`+`cur_i`)>>>1, computed on a 17-bit signed sum with arithmetic shift (rounds toward −∞). Same for Q.
  - `dac_valid`←1.
- All other edges: `dac_valid`←0; `dac_i`/`dac_q` hold.
- RUN→DRAIN: at the edge where cnt==`div_l` and `enable`=0.
- DRAIN→IDLE: at the edge where cnt==`div_l`. This clears `prev`/`cur`. The DRAIN period outputs the last sample, then last/2 (ramp to zero).
- `enable` re-asserted during DRAIN has no effect until IDLE is reached. The IDLE→RUN transition then follows immediately.
- `rate_div` changes are ignored except at IDLE→RUN.
- `underrun_clr` and an increment in the same cycle give `underrun_cnt`=1. `underrun_clr` alone gives 0.

## Timing
- Reset values (async `rst`): state IDLE, `cnt`=0, `wifi_iq_ready`=0, `dac_i`=`dac_q`=0, `dac_valid`=0, `underrun_cnt`=0. Reset mid-operation aborts immediately and produces no further strobes.
- First RUN cycle is cnt==0, so `wifi_iq_ready` is high 1 cycle after the edge that samples `enable`=1.
- `dac_valid` pulses in cycles with cnt==1 and cnt==`half`+1. With `div_l`=4 (100 MHz clock, 20 Msps): pulses at cnt 1 and 3, giving 40 Msps out.
- Latency: the sample captured with `wifi_iq_ready` appears unmodified on `dac_*` one input period + 1 cycle later.
- The data sequence starts 0, s0/2, s0, (s0+s1)/2, …

## Test plan
- Ramp-in: `rate_div`=4, valid I samples 1000, 2000, −3000.
  - `dac_i` sequence: 0, 500, 1000, 1500, 2000, −500.
  - `wifi_iq_ready` pulses every 5 cycles.
- Drain: drop `enable` after sample −3000.
  - Outputs continue −3000, −1500, then state IDLE.
  - No `wifi_iq_ready` after RUN ends; `dac_valid` stops.
- Underrun: hold `wifi_iq_valid`=0 for 3 strobes.
  - `underrun_cnt`=3, zeros shifted in.
  - `underrun_clr` and an underrun in the same cycle → `underrun_cnt`=1.
  - Forcing 65537 underruns saturates at 0xFFFF.
- Rounding/overflow:
  - prev=−1, cur=0 → −1.
  - 32767/32767 → 32767.
  - −32768/−32768 → −32768.
- Rate clamp: `rate_div`=1 → period 4 cycles. Changing `rate_div` mid-RUN has no effect until the next IDLE→RUN.
- Async `rst` asserted mid-period with `dac_valid` pending: all outputs 0 in the same cycle. After release with `enable`=1, `wifi_iq_ready` rises 1 cycle later.

Source files
------------

// File: rtl/tx_iq_dac_pace_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_iq_dac_pace_if
//  Description : Sample bus between tx_iq_intf and the DAC pacing stage.
//                Carries the FWFT I/Q pack with its valid/read-strobe
//                handshake and the paced DAC sample stream.
//                  wifi_iq_pack  : {..., q, i} word from tx_iq_intf
//                  wifi_iq_valid : pack holds valid data
//                  wifi_iq_ready : one-cycle read strobe back to tx_iq_intf
//                  dac_i/dac_q   : signed DAC samples
//                  dac_valid     : one-cycle strobe marking a new DAC sample
//                  master modport: producer of the pack, consumer of DAC data
//                  slave modport : the pacing stage
//  Revision    : 1.0 - initial release
// ============================================================================
interface tx_iq_dac_pace_if #(
    parameter int WIFI_IQ_PACK_DATA_WIDTH = 64,
    parameter int IQ_DATA_WIDTH           = 16
);
    logic [WIFI_IQ_PACK_DATA_WIDTH-1:0] wifi_iq_pack;
    logic                               wifi_iq_valid;
    logic                               wifi_iq_ready;
    logic signed [IQ_DATA_WIDTH-1:0]    dac_i;
    logic signed [IQ_DATA_WIDTH-1:0]    dac_q;
    logic                               dac_valid;

    modport master (
        output wifi_iq_pack,
        output wifi_iq_valid,
        input  wifi_iq_ready,
        input  dac_i,
        input  dac_q,
        input  dac_valid
    );

    modport slave (
        input  wifi_iq_pack,
        input  wifi_iq_valid,
        output wifi_iq_ready,
        output dac_i,
        output dac_q,
        output dac_valid
    );
endinterface
`default_nettype wire

// File: rtl/tx_iq_dac_pace.sv
`default_nettype none
// ============================================================================
//  Module      : tx_iq_dac_pace
//  Description : Sample pacing and 2x interpolation between tx_iq_intf and
//                the DAC front end. Issues a read strobe once per input
//                period, captures the low {q,i} word of the pack, and emits
//                two DAC samples per period: the previous sample, then the
//                midpoint of previous and newest. Ramps in from and out to
//                zero around enable, and counts strobes that found no data.
//  Ports       : clk, rst (async, active high)
//                enable       - run request
//                rate_div     - input period minus 1 in clocks (min 3)
//                iq           - sample bus (slave modport)
//                underrun_cnt - saturating underrun count
//                underrun_clr - synchronous clear of underrun_cnt
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_iq_dac_pace #(
    parameter int WIFI_IQ_PACK_DATA_WIDTH = 64,
    parameter int IQ_DATA_WIDTH           = 16,
    parameter int DIV_WIDTH               = 8
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  enable,
    input  wire [DIV_WIDTH-1:0]  rate_div,
    tx_iq_dac_pace_if.slave      iq,
    output logic [15:0]          underrun_cnt,
    input  wire                  underrun_clr
);

    localparam logic [1:0]           c_ST_IDLE      = 2'd0;
    localparam logic [1:0]           c_ST_RUN       = 2'd1;
    localparam logic [1:0]           c_ST_DRAIN     = 2'd2;
    localparam logic [DIV_WIDTH-1:0] c_DIV_MIN      = DIV_WIDTH'(3);
    localparam logic [15:0]          c_UNDERRUN_MAX = 16'hFFFF;

    logic [1:0]                      r_state;
    logic [1:0]                      w_state_nxt;
    logic [DIV_WIDTH-1:0]            r_cnt;
    logic [DIV_WIDTH-1:0]            r_div_l;
    logic [DIV_WIDTH:0]              w_half_ext;
    logic [DIV_WIDTH-1:0]            w_half;
    logic [DIV_WIDTH-1:0]            w_div_clamped;

    logic signed [IQ_DATA_WIDTH-1:0] r_prev_i, r_prev_q;
    logic signed [IQ_DATA_WIDTH-1:0] r_cur_i,  r_cur_q;
    logic signed [IQ_DATA_WIDTH-1:0] r_dac_i,  r_dac_q;
    logic                            r_dac_valid;
    logic [15:0]                     r_underrun_cnt;

    logic                            w_active;
    logic                            w_at_zero;
    logic                            w_at_half;
    logic                            w_at_end;
    logic                            w_take;
    logic                            w_underrun;
    logic signed [IQ_DATA_WIDTH-1:0] w_smp_i, w_smp_q;
    logic signed [IQ_DATA_WIDTH:0]   w_sum_i, w_sum_q;
    logic signed [IQ_DATA_WIDTH-1:0] w_mid_i, w_mid_q;

    // Only the low {q,i} word of the pack is consumed.
    generate
        if (WIFI_IQ_PACK_DATA_WIDTH > 2*IQ_DATA_WIDTH) begin : g_pack_tail
            logic w_unused_pack_hi;
            assign w_unused_pack_hi =
                ^iq.wifi_iq_pack[WIFI_IQ_PACK_DATA_WIDTH-1:2*IQ_DATA_WIDTH];
        end
    endgenerate

    // Periods shorter than 4 clocks would collide the capture and midpoint
    // slots, so the divider is clamped.
    assign w_div_clamped = (rate_div < c_DIV_MIN) ? c_DIV_MIN : rate_div;
    assign w_half_ext    = {1'b0, r_div_l} + (DIV_WIDTH+1)'(1);
    assign w_half        = DIV_WIDTH'(w_half_ext >> 1);

    assign w_active  = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);
    assign w_at_zero = w_active && (r_cnt == '0);
    assign w_at_half = w_active && (r_cnt == w_half);
    assign w_at_end  = w_active && (r_cnt == r_div_l);

    // In DRAIN (or on an empty strobe) zeros are shifted in so the output
    // ramps down to zero instead of repeating stale data.
    assign w_take     = (r_state == c_ST_RUN) && iq.wifi_iq_valid;
    assign w_underrun = w_at_zero && (r_state == c_ST_RUN) && !iq.wifi_iq_valid;
    assign w_smp_i    = w_take ? iq.wifi_iq_pack[IQ_DATA_WIDTH-1:0] : '0;
    assign w_smp_q    = w_take ? iq.wifi_iq_pack[2*IQ_DATA_WIDTH-1:IQ_DATA_WIDTH] : '0;

    // One guard bit keeps the sum exact; the arithmetic shift rounds toward
    // minus infinity and the mean always fits back into the sample width.
    assign w_sum_i = {r_prev_i[IQ_DATA_WIDTH-1], r_prev_i} + {r_cur_i[IQ_DATA_WIDTH-1], r_cur_i};
    assign w_sum_q = {r_prev_q[IQ_DATA_WIDTH-1], r_prev_q} + {r_cur_q[IQ_DATA_WIDTH-1], r_cur_q};
    assign w_mid_i = IQ_DATA_WIDTH'(w_sum_i >>> 1);
    assign w_mid_q = IQ_DATA_WIDTH'(w_sum_q >>> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (w_at_end && !enable) w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                // enable is ignored here; IDLE re-enters RUN on the next edge.
                if (w_at_end) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_div_l     <= c_DIV_MIN;
            r_prev_i    <= '0;
            r_prev_q    <= '0;
            r_cur_i     <= '0;
            r_cur_q     <= '0;
            r_dac_i     <= '0;
            r_dac_q     <= '0;
            r_dac_valid <= 1'b0;
        end else begin
            r_dac_valid <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                r_cnt    <= '0;
                r_prev_i <= '0;
                r_prev_q <= '0;
                r_cur_i  <= '0;
                r_cur_q  <= '0;
                if (enable) r_div_l <= w_div_clamped;
            end else begin
                r_cnt <= w_at_end ? '0 : r_cnt + DIV_WIDTH'(1);
                if (w_at_zero) begin
                    r_prev_i    <= r_cur_i;
                    r_prev_q    <= r_cur_q;
                    r_cur_i     <= w_smp_i;
                    r_cur_q     <= w_smp_q;
                    r_dac_i     <= r_cur_i;
                    r_dac_q     <= r_cur_q;
                    r_dac_valid <= 1'b1;
                end else if (w_at_half) begin
                    r_dac_i     <= w_mid_i;
                    r_dac_q     <= w_mid_q;
                    r_dac_valid <= 1'b1;
                end
                if ((r_state == c_ST_DRAIN) && w_at_end) begin
                    r_prev_i <= '0;
                    r_prev_q <= '0;
                    r_cur_i  <= '0;
                    r_cur_q  <= '0;
                end
            end
        end
    end

    // A clear coinciding with an underrun leaves that underrun counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (underrun_clr) begin
            r_underrun_cnt <= w_underrun ? 16'd1 : 16'd0;
        end else if (w_underrun && (r_underrun_cnt != c_UNDERRUN_MAX)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    // The strobe is decoded from registers only, so reset removes it at once.
    assign iq.wifi_iq_ready = (r_state == c_ST_RUN) && (r_cnt == '0);
    assign iq.dac_i         = r_dac_i;
    assign iq.dac_q         = r_dac_q;
    assign iq.dac_valid     = r_dac_valid;
    assign underrun_cnt     = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tx_iq_dac_pace.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_iq_dac_pace
//  Description : Directed self-checking bench for tx_iq_dac_pace. Feeds
//                sample tables on each read strobe, logs DAC samples and
//                strobe cycles, and compares against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_iq_dac_pace;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  rate_div;
    logic [15:0] underrun_cnt;
    logic        underrun_clr;

    tx_iq_dac_pace_if #(.WIFI_IQ_PACK_DATA_WIDTH(64), .IQ_DATA_WIDTH(16)) bus ();

    tx_iq_dac_pace #(
        .WIFI_IQ_PACK_DATA_WIDTH(64),
        .IQ_DATA_WIDTH(16),
        .DIV_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .rate_div     (rate_div),
        .iq           (bus.slave),
        .underrun_cnt (underrun_cnt),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int t0;
    int feed_idx;
    int feed_n;
    bit took;
    logic signed [15:0] feed_i [16];
    logic signed [15:0] feed_q [16];
    bit                 feed_v [16];
    int oi[$];
    int oq[$];
    int vcyc[$];
    int rcyc[$];

    int exp_ramp_i [8]  = '{0, 500, 1000, 1500, 2000, -500, -3000, -1500};
    int exp_ramp_q [8]  = '{0, -5, -10, 5, 20, 25, 30, 15};
    int exp_und_i  [10] = '{0, 400, 800, 400, 0, 0, 0, 0, 0, 0};
    int exp_rnd_i  [14] = '{0, -1, -1, -1, 0, 16383, 32767, 32767, 32767, -1,
                            -32768, -32768, -32768, -16384};

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_feed(input int k, input logic signed [15:0] vi,
                            input logic signed [15:0] vq, input bit vv);
        feed_i[k] = vi;
        feed_q[k] = vq;
        feed_v[k] = vv;
    endtask

    task automatic clear_logs();
        oi.delete();
        oq.delete();
        vcyc.delete();
        rcyc.delete();
        feed_idx = 0;
        took     = 1'b0;
    endtask

    // One clock: present the current feed entry, log strobes and outputs.
    task automatic step();
        @(negedge clk);
        if (took) begin
            feed_idx++;
            took = 1'b0;
        end
        if (feed_idx < feed_n) begin
            bus.wifi_iq_pack  = {32'hDEAD_BEEF, feed_q[feed_idx], feed_i[feed_idx]};
            bus.wifi_iq_valid = feed_v[feed_idx];
        end else begin
            bus.wifi_iq_pack  = {32'hDEAD_BEEF, 32'h1111_2222};
            bus.wifi_iq_valid = 1'b0;
        end
        if (bus.wifi_iq_ready === 1'b1) begin
            took = 1'b1;
            rcyc.push_back(cyc);
        end
        if (bus.dac_valid === 1'b1) begin
            oi.push_back(int'(bus.dac_i));
            oq.push_back(int'(bus.dac_q));
            vcyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic wait_ready(input int n);
        int k;
        k = 0;
        while (rcyc.size() < n && k < 200) begin
            step();
            k++;
        end
        if (rcyc.size() < n) check("ready_timeout", rcyc.size(), n);
    endtask

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -999999;
    endfunction

    initial begin
        rst               = 1'b1;
        enable            = 1'b0;
        rate_div          = 8'd4;
        underrun_clr      = 1'b0;
        bus.wifi_iq_pack  = '0;
        bus.wifi_iq_valid = 1'b0;
        feed_n            = 0;
        clear_logs();

        // Reset state
        repeat (3) step();
        check("rst_ready",    int'(bus.wifi_iq_ready), 0);
        check("rst_dac_i",    int'(bus.dac_i), 0);
        check("rst_dac_q",    int'(bus.dac_q), 0);
        check("rst_dac_valid",int'(bus.dac_valid), 0);
        check("rst_underrun", int'(underrun_cnt), 0);
        rst = 1'b0;
        repeat (2) step();

        // Ramp-in and drain, rate_div = 4
        clear_logs();
        set_feed(0, 16'sd1000, -16'sd10, 1'b1);
        set_feed(1, 16'sd2000, 16'sd20, 1'b1);
        set_feed(2, -16'sd3000, 16'sd30, 1'b1);
        feed_n   = 3;
        rate_div = 8'd4;
        enable   = 1'b1;
        t0       = cyc;
        wait_ready(3);
        enable = 1'b0;
        repeat (20) step();
        check("ramp_first_ready", at(rcyc, 0), t0);
        check("ramp_ready_gap1", at(rcyc, 1) - at(rcyc, 0), 5);
        check("ramp_ready_gap2", at(rcyc, 2) - at(rcyc, 1), 5);
        check("drain_no_ready", rcyc.size(), 3);
        check("ramp_valid_cnt1", at(vcyc, 0), at(rcyc, 0) + 1);
        check("ramp_valid_cnt3", at(vcyc, 1), at(rcyc, 0) + 3);
        check("ramp_latency", at(vcyc, 2), at(rcyc, 0) + 6);
        check("ramp_out_count", oi.size(), 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("ramp_i[%0d]", k), at(oi, k), exp_ramp_i[k]);
            check($sformatf("ramp_q[%0d]", k), at(oq, k), exp_ramp_q[k]);
        end

        // Underrun: one good sample then three empty strobes
        clear_logs();
        set_feed(0, 16'sd800, 16'sd0, 1'b1);
        set_feed(1, 16'sd7777, 16'sd7777, 1'b0);
        set_feed(2, 16'sd7777, 16'sd7777, 1'b0);
        set_feed(3, 16'sd7777, 16'sd7777, 1'b0);
        feed_n = 4;
        enable = 1'b1;
        wait_ready(4);
        enable = 1'b0;
        repeat (20) step();
        check("underrun_three", int'(underrun_cnt), 3);
        check("underrun_out_count", oi.size(), 10);
        for (int k = 0; k < 10; k++)
            check($sformatf("underrun_i[%0d]", k), at(oi, k), exp_und_i[k]);

        // Clear together with an underrun, then clear alone
        clear_logs();
        feed_n = 0;
        enable = 1'b1;
        wait_ready(1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("clr_with_inc", int'(underrun_cnt), 1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        check("clr_alone", int'(underrun_cnt), 0);

        // Saturation: seed the counter just below full scale
        force dut.r_underrun_cnt = 16'hFFFE;
        #1;
        release dut.r_underrun_cnt;
        wait_ready(2);
        step();
        check("sat_reach", int'(underrun_cnt), 65535);
        wait_ready(3);
        step();
        check("sat_hold", int'(underrun_cnt), 65535);
        enable = 1'b0;
        repeat (12) step();

        // Rounding / overflow, clamped rate, rate change mid-run ignored
        clear_logs();
        set_feed(0, -16'sd1, 16'sd5, 1'b1);
        set_feed(1, 16'sd0, 16'sd5, 1'b1);
        set_feed(2, 16'sd32767, 16'sd5, 1'b1);
        set_feed(3, 16'sd32767, 16'sd5, 1'b1);
        set_feed(4, -16'sd32768, 16'sd5, 1'b1);
        set_feed(5, -16'sd32768, 16'sd5, 1'b1);
        feed_n   = 6;
        rate_div = 8'd1;
        enable   = 1'b1;
        wait_ready(2);
        rate_div = 8'd20;
        wait_ready(6);
        enable = 1'b0;
        repeat (20) step();
        check("clamp_gap", at(rcyc, 1) - at(rcyc, 0), 4);
        check("rate_change_ignored", at(rcyc, 5) - at(rcyc, 4), 4);
        check("round_out_count", oi.size(), 14);
        check("round_q_mid", at(oq, 1), 2);
        for (int k = 0; k < 14; k++)
            check($sformatf("round_i[%0d]", k), at(oi, k), exp_rnd_i[k]);

        // Async reset mid-period with a DAC strobe pending
        clear_logs();
        set_feed(0, 16'sd1234, -16'sd88, 1'b1);
        feed_n   = 1;
        rate_div = 8'd4;
        enable   = 1'b1;
        wait_ready(1);
        repeat (3) step();
        check("pre_rst_valid", int'(bus.dac_valid), 1);
        check("pre_rst_i", int'(bus.dac_i), 617);
        check("pre_rst_q", int'(bus.dac_q), -44);
        rst = 1'b1;
        #1;
        check("arst_ready", int'(bus.wifi_iq_ready), 0);
        check("arst_valid", int'(bus.dac_valid), 0);
        check("arst_i", int'(bus.dac_i), 0);
        check("arst_q", int'(bus.dac_q), 0);
        check("arst_underrun", int'(underrun_cnt), 0);
        repeat (2) step();
        check("rst_no_strobe", rcyc.size(), 1);
        rst = 1'b0;
        step();
        check("ready_after_rst", int'(bus.wifi_iq_ready), 1);
        enable = 1'b0;
        repeat (12) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
